// File: rtl/gcd_job_dispatcher.sv
// gcd_job_dispatcher: queues (a, b, tag) jobs in a small FIFO and feeds them one
// at a time to the multi-cycle gcd engine, returning (res, tag) on a valid/ready port.
// Optional watchdog abort of a stuck engine: define GCD_DISP_TIMEOUT_EN.
module gcd_job_dispatcher #(
    parameter int unsigned WIDTH   = 41,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             eng_start,
    output logic [WIDTH-1:0] eng_a,
    output logic [WIDTH-1:0] eng_b,
    input  logic             eng_done,
    input  logic [WIDTH-1:0] eng_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_timeout,
    output logic             busy
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = 2 * WIDTH + TAG_W;
    localparam int unsigned WD_W    = 16;

    // Reject configurations the pointer wrap and watchdog cannot support.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
        $error("gcd_job_dispatcher: DEPTH must be a power of 2 >= 2, TIMEOUT in 1..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BLANK = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [ENTRY_W-1:0] rd_entry;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [TAG_W-1:0]   job_tag;
    logic               push;
    logic               pop;
    logic               capture_res;
`ifdef GCD_DISP_TIMEOUT_EN
    logic [WD_W-1:0]    wd_cnt;
    logic               capture_to;
`endif

    assign rd_entry = fifo_mem[rd_ptr];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, FIFO pop/push and capture strobes.
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        capture_res = 1'b0;
`ifdef GCD_DISP_TIMEOUT_EN
        capture_to  = 1'b0;
`endif
        push        = in_valid && in_ready;
        unique case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: state_next = S_BLANK;
            // eng_done may still show the previous job here; it is not looked at.
            S_BLANK: state_next = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    capture_res = 1'b1;
                    state_next  = S_OUT;
                end
`ifdef GCD_DISP_TIMEOUT_EN
                else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    capture_to = 1'b1;
                    state_next = S_OUT;
                end
`endif
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        unique case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_a, in_b, in_tag};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
        end
    end

    // Issued job operands; held until the next pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_a   <= '0;
            eng_b   <= '0;
            job_tag <= '0;
        end else if (pop) begin
            {eng_a, eng_b, job_tag} <= rd_entry;
        end
    end

    // Registered handshake/status outputs derived from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            eng_start <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            eng_start <= (state_next == S_START);
            out_valid <= (state_next == S_OUT);
            in_ready  <= (count_next != CNT_W'(DEPTH));
            busy      <= (state_next != S_IDLE) || (count_next != '0);
        end
    end

    // Result capture; eng_res is sampled only when leaving WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_res <= '0;
            out_tag <= '0;
        end else if (capture_res) begin
            out_res <= eng_res;
            out_tag <= job_tag;
        end
`ifdef GCD_DISP_TIMEOUT_EN
        else if (capture_to) begin
            out_res <= '0;
            out_tag <= job_tag;
        end
`endif
    end

`ifdef GCD_DISP_TIMEOUT_EN
    // Watchdog: cleared entering WAIT, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == S_BLANK) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Abort flag set with the zero result, cleared on result handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_timeout <= 1'b0;
        end else if (capture_to) begin
            out_timeout <= 1'b1;
        end else if (state == S_OUT && out_ready) begin
            out_timeout <= 1'b0;
        end
    end
`else
    assign out_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Bench for gcd_job_dispatcher with a stub gcd engine and a result scoreboard.
module tb_gcd_job_dispatcher;

    localparam int unsigned W  = 41;
    localparam int unsigned TW = 4;
`ifdef GCD_DISP_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 20;
`else
    localparam int unsigned TB_TIMEOUT = 1023;
`endif

    typedef struct {
        logic [W-1:0]  res;
        logic [TW-1:0] tag;
        logic          to;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [TW-1:0] in_tag = '0;
    logic          eng_start;
    logic [W-1:0]  eng_a;
    logic [W-1:0]  eng_b;
    logic          eng_done = 1'b1;
    logic [W-1:0]  eng_res = W'(99);
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
    logic          out_timeout;
    logic          busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   start_cnt = 0;
    int   last_start_cyc = 0;
    exp_t exp_q[$];

    // Stub engine state
    int           stub_dly = 4;
    logic         stub_hang = 1'b0;
    logic         stub_running = 1'b0;
    logic         stub_lag = 1'b0;
    int           stub_cnt = 0;
    logic [W-1:0] stub_pend = '0;

    gcd_job_dispatcher #(
        .WIDTH(W), .DEPTH(4), .TAG_W(TW), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b),
        .eng_done(eng_done), .eng_res(eng_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_tag(out_tag), .out_timeout(out_timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] stub_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x = a;
        logic [W-1:0] y = b;
        logic [W-1:0] t;
        for (int i = 0; i < 200; i++) begin
            if (y == '0) break;
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Stub engine: done drops one cycle after load, rises stub_dly cycles later, then stays high.
    always @(posedge clk) begin
        if (eng_start) begin
            stub_pend    <= stub_gcd(eng_a, eng_b);
            stub_cnt     <= stub_dly;
            stub_lag     <= 1'b1;
            stub_running <= !stub_hang;
        end else begin
            if (stub_lag) begin
                stub_lag <= 1'b0;
                eng_done <= 1'b0;
            end
            if (stub_running && !stub_lag) begin
                if (stub_cnt <= 1) begin
                    eng_done     <= 1'b1;
                    eng_res      <= stub_pend;
                    stub_running <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag,
                            input logic [W-1:0] er, input logic eto);
        int n = 0;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            chk("push_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{res: er, tag: tag, to: eto});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) chk(name, 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: start pulse rules and scoreboard compare on every result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (eng_start) begin
                    chk("engine_overlap", 64'(stub_running), 64'(0));
                    if (start_cnt > 0) chk("start_gap_ge5", 64'((cyc - last_start_cyc) >= 5), 64'(1));
                    start_cnt++;
                    last_start_cyc = cyc;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_result: res=%0d tag=%0d with empty scoreboard", out_res, out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_res", 64'(out_res), 64'(e.res));
                        chk("out_tag", 64'(out_tag), 64'(e.tag));
                        chk("out_timeout", 64'(out_timeout), 64'(e.to));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "global timeout");
    end

    initial begin
        int sc;
        int n;
        repeat (3) tick();
        reset = 1'b0;
        // Reset values
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_eng_start", 64'(eng_start), 64'(0));
        chk("rst_eng_a", 64'(eng_a), 64'(0));
        chk("rst_eng_b", 64'(eng_b), 64'(0));
        chk("rst_out_res", 64'(out_res), 64'(0));
        chk("rst_out_tag", 64'(out_tag), 64'(0));
        chk("rst_out_timeout", 64'(out_timeout), 64'(0));

        // Single job with stale done already high from the stub's idle state
        stub_dly = 4;
        push_job(12, 18, 3, 6, 0);
        n = 0;
        while (!eng_start && n < 20) begin tick(); n++; end
        chk("t1_eng_a", 64'(eng_a), 64'(12));
        chk("t1_eng_b", 64'(eng_b), 64'(18));
        wait_idle("t1_idle");
        chk("t1_start_cnt", 64'(start_cnt), 64'(1));

        // Stale done=1 with eng_res=6 left from the previous job
        push_job(35, 14, 5, 7, 0);
        wait_idle("t2_idle");
        chk("t2_start_cnt", 64'(start_cnt), 64'(2));

        // Fill: first job goes to the engine, next four fill the FIFO
        stub_dly = 30;
        push_job(12, 8, 0, 4, 0);
        push_job(9, 6, 1, 3, 0);
        push_job(100, 75, 2, 25, 0);
        push_job(17, 5, 3, 1, 0);
        chk("fill_ready_before_last", 64'(in_ready), 64'(1));
        push_job(48, 36, 4, 12, 0);
        chk("fill_in_ready_full", 64'(in_ready), 64'(0));
        chk("fill_busy", 64'(busy), 64'(1));
        wait_idle("fill_idle");
        chk("fill_start_cnt", 64'(start_cnt), 64'(7));

        // Backpressure in OUT
        stub_dly = 4;
        out_ready = 1'b0;
        push_job(21, 14, 6, 7, 0);
        push_job(10, 4, 7, 2, 0);
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        sc = start_cnt;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_out_res", 64'(out_res), 64'(7));
            chk("bp_out_tag", 64'(out_tag), 64'(6));
            tick();
        end
        chk("bp_no_start", 64'(start_cnt), 64'(sc));
        out_ready = 1'b1;
        wait_idle("bp_idle");
        chk("bp_start_cnt", 64'(start_cnt), 64'(9));

        // Reset while in WAIT with two jobs queued
        stub_dly = 20;
        sc = start_cnt;
        push_job(30, 12, 8, 6, 0);
        push_job(8, 4, 9, 4, 0);
        push_job(27, 18, 10, 9, 0);
        n = 0;
        while ((start_cnt == sc || cyc < last_start_cyc + 2) && n < 50) begin tick(); n++; end
        chk("rw_started", 64'(start_cnt), 64'(sc + 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        chk("rw_out_valid", 64'(out_valid), 64'(0));
        chk("rw_busy", 64'(busy), 64'(0));
        chk("rw_in_ready", 64'(in_ready), 64'(1));
        repeat (40) tick();
        chk("rw_no_start", 64'(start_cnt), 64'(sc + 1));
        chk("rw_still_idle", 64'(busy), 64'(0));

`ifdef GCD_DISP_TIMEOUT_EN
        // Watchdog abort, then the next queued job runs normally
        stub_dly = 4;
        stub_hang = 1'b1;
        sc = start_cnt;
        push_job(5, 5, 1, 0, 1);
        push_job(9, 6, 2, 3, 0);
        n = 0;
        while (start_cnt == sc && n < 20) begin tick(); n++; end
        stub_hang = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin tick(); n++; end
        chk("to_latency", 64'(cyc - last_start_cyc), 64'(22));
        chk("to_flag", 64'(out_timeout), 64'(1));
        chk("to_res", 64'(out_res), 64'(0));
        wait_idle("to_idle");
        chk("to_start_cnt", 64'(start_cnt), 64'(sc + 2));
`endif

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
